// File: rtl/sensor_input_conditioner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sensor_input_conditioner                                     |
// | Description : Synchronises, debounces and warm-up gates the six raw field  |
// |               sensor lines feeding the irrigation controller.              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module sensor_input_conditioner #(
  parameter int SAMPLE_DIV     = 1000,
  parameter int STABLE_SAMPLES = 4,
  parameter int DIV_W          = 10,
  parameter int CNT_W          = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] raw_sensors,
  output logic [5:0] clean_sensors,
  output logic       sensors_ready,
  output logic       sensors_changed,
  output logic       sample_tick
);

  localparam int                 C_NUM_CH   = 6;
  localparam logic [DIV_W-1:0]   C_DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [CNT_W-1:0]   C_CNT_LAST = CNT_W'(STABLE_SAMPLES - 1);

  typedef enum logic [0:0] {
    ST_WARMUP = 1'b0,
    ST_RUN    = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [5:0]          sync_meta_q, sync_meta_d;
  logic [5:0]          sync_q, sync_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [CNT_W-1:0]    warm_cnt_q, warm_cnt_d;
  logic [CNT_W-1:0]    cnt_q [C_NUM_CH];
  logic [CNT_W-1:0]    cnt_d [C_NUM_CH];
  logic [5:0]          clean_q, clean_d;
  logic                ready_q, ready_d;
  logic                commit_q, commit_d;
  logic                changed_q, changed_d;

  logic                w_tick;
  logic                w_run_tick;
  logic [5:0]          w_commit;

  assign w_tick     = (div_q == C_DIV_LAST);
  assign w_run_tick = w_tick && (state_q == ST_RUN);

  // Per-channel stability counters; a counter only advances while the
  // synchronised input disagrees with the committed value on a tick.
  for (genvar i = 0; i < C_NUM_CH; i++) begin : g_ch
    logic w_diff;
    logic w_last;

    assign w_diff      = (sync_q[i] != clean_q[i]);
    assign w_last      = (cnt_q[i] == C_CNT_LAST);
    assign w_commit[i] = w_run_tick && w_diff && w_last;

    always_comb begin
      cnt_d[i] = cnt_q[i];
      if (state_q != ST_RUN) begin
        cnt_d[i] = '0;
      end else if (w_tick) begin
        if (!w_diff || w_last) begin
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    sync_meta_d = raw_sensors;
    sync_d      = sync_meta_q;
    div_d       = (div_q == C_DIV_LAST) ? '0 : div_q + 1'b1;
    warm_cnt_d  = warm_cnt_q;
    clean_d     = clean_q;
    ready_d     = ready_q;
    commit_d    = 1'b0;
    changed_d   = commit_q;

    case (state_q)
      ST_WARMUP: begin
        if (w_tick) begin
          if (warm_cnt_q == C_CNT_LAST) begin
            // Initial load is not a change event for downstream logic.
            clean_d    = sync_q;
            ready_d    = 1'b1;
            warm_cnt_d = '0;
            state_d    = ST_RUN;
          end else begin
            warm_cnt_d = warm_cnt_q + 1'b1;
          end
        end
      end
      ST_RUN: begin
        clean_d  = (clean_q & ~w_commit) | (sync_q & w_commit);
        commit_d = |w_commit;
      end
      default: begin
        state_d = ST_WARMUP;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_WARMUP;
      sync_meta_q <= '0;
      sync_q      <= '0;
      div_q       <= '0;
      warm_cnt_q  <= '0;
      clean_q     <= '0;
      ready_q     <= 1'b0;
      commit_q    <= 1'b0;
      changed_q   <= 1'b0;
      for (int i = 0; i < C_NUM_CH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      sync_meta_q <= sync_meta_d;
      sync_q      <= sync_d;
      div_q       <= div_d;
      warm_cnt_q  <= warm_cnt_d;
      clean_q     <= clean_d;
      ready_q     <= ready_d;
      commit_q    <= commit_d;
      changed_q   <= changed_d;
      for (int i = 0; i < C_NUM_CH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign clean_sensors   = clean_q;
  assign sensors_ready   = ready_q;
  assign sensors_changed = changed_q;
  // Masked during reset so a divide-by-one build does not pulse while held.
  assign sample_tick     = w_tick && !reset;

endmodule
`default_nettype wire
